// File: rtl/xlr8_prbs_chk_pkg.sv
// xlr8_prbs_chk_pkg: shared types, register bit positions and helper
// functions for the XLR8 PRBS receive checker.
package xlr8_prbs_chk_pkg;

    // Checker state, encoded exactly as reported in STAT[1:0]
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        VERIFY = 2'd2,
        LOCKED = 2'd3
    } chk_state_t;

    // CTRL register bits
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    // STAT register bits (state occupies [1:0])
    localparam int STAT_ERR_BIT = 2;
    localparam int STAT_SAT_BIT = 3;

    // One LFSR advance: shift left, feedback is parity of the tapped bits
    function automatic logic [7:0] lfsr_step(input logic [7:0] x, input logic [7:0] taps);
        return {x[6:0], ^(x & taps)};
    endfunction

    // Number of set bits in a byte (0..8)
    function automatic logic [3:0] popcount8(input logic [7:0] x);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, x[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/xlr8_prbs_chk_fsm.sv
// xlr8_prbs_chk_fsm: stream synchroniser for the PRBS checker. Owns the
// checker state, the byte predictor and the verify/loss run counters, and
// emits a same-cycle error pulse with its increment for the top-level
// error counter. Optional macro XLR8_PRBS_CHK_BITERR_EN makes the
// increment the number of differing bits instead of one per byte.
module xlr8_prbs_chk_fsm
    import xlr8_prbs_chk_pkg::*;
#(
    parameter logic [7:0]  TAPS     = 8'hB8,
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned LOSS_THR = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clken,
    input  logic       ctrl_we,
    input  logic       en_cur,
    input  logic       en_new,
    input  logic       clr,
    input  logic       data_we,
    input  logic [7:0] data_byte,
    output chk_state_t state,
    output logic       err_pulse,
    output logic       lock_match,
    output logic [3:0] inc
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_THR);

    logic [7:0] pred;
    logic [7:0] exp_byte;
    logic [3:0] vcnt;
    logic [3:0] lcnt;
    logic       data_act;

    assign exp_byte = lfsr_step(pred, TAPS);
    // A CTRL write wins if both decodes ever land on the same address
    assign data_act = clken && data_we && en_cur && !ctrl_we;

    // Per-byte verdict while locked; consumed by the error counter this edge
    always_comb begin
        err_pulse  = 1'b0;
        lock_match = 1'b0;
        if (data_act && state == LOCKED) begin
            err_pulse  = (data_byte != exp_byte);
            lock_match = (data_byte == exp_byte);
        end
`ifdef XLR8_PRBS_CHK_BITERR_EN
        inc = popcount8(data_byte ^ exp_byte);
`else
        inc = 4'd1;
`endif
    end

    // Sync state machine: control writes take precedence over stream bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pred  <= 8'h00;
            vcnt  <= 4'd0;
            lcnt  <= 4'd0;
        end else if (clken) begin
            if (ctrl_we) begin
                if (clr) begin
                    vcnt <= 4'd0;
                    lcnt <= 4'd0;
                end
                if (!en_new) begin
                    state <= IDLE;
                end else if (!en_cur || clr) begin
                    state <= HUNT;
                end
            end else if (data_act) begin
                case (state)
                    IDLE: ;
                    HUNT: begin
                        // All-zero is the LFSR lock-up value and cannot seed
                        if (data_byte != 8'h00) begin
                            pred  <= data_byte;
                            vcnt  <= 4'd0;
                            state <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (data_byte == exp_byte) begin
                            pred <= exp_byte;
                            vcnt <= vcnt + 4'd1;
                            if (vcnt + 4'd1 == LOCK_N) begin
                                state <= LOCKED;
                                lcnt  <= 4'd0;
                            end
                        end else if (data_byte == 8'h00) begin
                            state <= HUNT;
                        end else begin
                            pred <= data_byte;
                            vcnt <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: the predictor never reseeds from data here
                        pred <= exp_byte;
                        if (data_byte == exp_byte) begin
                            lcnt <= 4'd0;
                        end else if (lcnt + 4'd1 == LOSS_N) begin
                            state <= HUNT;
                            lcnt  <= 4'd0;
                        end else begin
                            lcnt <= lcnt + 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/xlr8_prbs_chk.sv
// xlr8_prbs_chk: AVR data-memory Xcelerator Block that checks a received
// XLR8 LFSR byte stream. Holds bus decode, CTRL, the saturating 16-bit
// error counter and the ERRH shadow used for atomic 16-bit reads.
// Optional macro XLR8_PRBS_CHK_BITERR_EN counts bit errors rather than
// byte errors; register map is the same either way.
module xlr8_prbs_chk
    import xlr8_prbs_chk_pkg::*;
#(
    parameter logic [7:0]  CTRL_ADDR = 8'h00,
    parameter logic [7:0]  DATA_ADDR = 8'h00,
    parameter logic [7:0]  STAT_ADDR = 8'h00,
    parameter logic [7:0]  ERRL_ADDR = 8'h00,
    parameter logic [7:0]  ERRH_ADDR = 8'h00,
    parameter logic [7:0]  TAPS      = 8'hB8,
    parameter int unsigned LOCK_CNT  = 3,
    parameter int unsigned LOSS_THR  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clken,
    input  logic [7:0] dbus_in,
    output logic [7:0] dbus_out,
    output logic       io_out_en,
    input  logic [7:0] ramadr,
    input  logic       ramre,
    input  logic       ramwe,
    input  logic       dm_sel
);

    logic       ctrl_sel, data_sel, stat_sel, errl_sel, errh_sel;
    logic       ctrl_we, data_we, clr;
    logic       en;
    logic [15:0] errcnt;
    logic [15:0] errcnt_nxt;
    logic       sat;
    logic       last_err;
    logic [7:0] errh_shadow;
    logic [7:0] stat_val;
    chk_state_t state;
    logic       err_pulse;
    logic       lock_match;
    logic [3:0] inc;

    // Add with clamp at all-ones
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign ctrl_sel = dm_sel && (ramadr == CTRL_ADDR);
    assign data_sel = dm_sel && (ramadr == DATA_ADDR);
    assign stat_sel = dm_sel && (ramadr == STAT_ADDR);
    assign errl_sel = dm_sel && (ramadr == ERRL_ADDR);
    assign errh_sel = dm_sel && (ramadr == ERRH_ADDR);

    assign ctrl_we = ctrl_sel && ramwe;
    assign data_we = data_sel && ramwe;
    assign clr     = ctrl_we && dbus_in[CTRL_CLR_BIT];

    assign errcnt_nxt = sat_add16(errcnt, inc);

    xlr8_prbs_chk_fsm #(
        .TAPS     (TAPS),
        .LOCK_CNT (LOCK_CNT),
        .LOSS_THR (LOSS_THR)
    ) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .clken      (clken),
        .ctrl_we    (ctrl_we),
        .en_cur     (en),
        .en_new     (dbus_in[CTRL_EN_BIT]),
        .clr        (clr),
        .data_we    (data_we),
        .data_byte  (dbus_in),
        .state      (state),
        .err_pulse  (err_pulse),
        .lock_match (lock_match),
        .inc        (inc)
    );

    // CTRL.EN register
    always_ff @(posedge clk) begin
        if (rst) begin
            en <= 1'b0;
        end else if (clken && ctrl_we) begin
            en <= dbus_in[CTRL_EN_BIT];
        end
    end

    // Error counter, sticky SAT and LAST_ERR; CLR beats a same-cycle error
    always_ff @(posedge clk) begin
        if (rst) begin
            errcnt   <= 16'h0000;
            sat      <= 1'b0;
            last_err <= 1'b0;
        end else if (clken) begin
            if (clr) begin
                errcnt   <= 16'h0000;
                sat      <= 1'b0;
                last_err <= 1'b0;
            end else if (err_pulse) begin
                errcnt   <= errcnt_nxt;
                sat      <= sat || (errcnt_nxt == 16'hFFFF);
                last_err <= 1'b1;
            end else if (lock_match) begin
                last_err <= 1'b0;
            end
        end
    end

    // Capture the high byte when the low byte is read
    always_ff @(posedge clk) begin
        if (rst) begin
            errh_shadow <= 8'h00;
        end else if (clken && errl_sel && ramre) begin
            errh_shadow <= errcnt[15:8];
        end
    end

    assign stat_val = {4'b0000, sat, last_err, state};

    // Zero-latency read mux; DATA is a write-only sink
    always_comb begin
        dbus_out = 8'h00;
        if (ctrl_sel) dbus_out = dbus_out | {7'd0, en};
        if (stat_sel) dbus_out = dbus_out | stat_val;
        if (errl_sel) dbus_out = dbus_out | errcnt[7:0];
        if (errh_sel) dbus_out = dbus_out | errh_shadow;
        io_out_en = ramre && (ctrl_sel || stat_sel || errl_sel || errh_sel);
    end

endmodule

// File: tb/tb_xlr8_prbs_chk.sv
// Directed bench for xlr8_prbs_chk; expected values are hand-derived from
// the LFSR sequence 01 02 04 08 11 23 47 8E 1C (TAPS = B8).
module tb_xlr8_prbs_chk;

    localparam logic [7:0] A_CTRL = 8'h10;
    localparam logic [7:0] A_DATA = 8'h11;
    localparam logic [7:0] A_STAT = 8'h12;
    localparam logic [7:0] A_ERRL = 8'h13;
    localparam logic [7:0] A_ERRH = 8'h14;

`ifdef XLR8_PRBS_CHK_BITERR_EN
    localparam logic [7:0] EXP_ERR1 = 8'h02;
    localparam logic [7:0] EXP_LOSS = 8'h0F;
`else
    localparam logic [7:0] EXP_ERR1 = 8'h01;
    localparam logic [7:0] EXP_LOSS = 8'h04;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       clken;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;
    logic       io_out_en;
    logic [7:0] ramadr;
    logic       ramre;
    logic       ramwe;
    logic       dm_sel;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    xlr8_prbs_chk #(
        .CTRL_ADDR (A_CTRL),
        .DATA_ADDR (A_DATA),
        .STAT_ADDR (A_STAT),
        .ERRL_ADDR (A_ERRL),
        .ERRH_ADDR (A_ERRH),
        .TAPS      (8'hB8),
        .LOCK_CNT  (3),
        .LOSS_THR  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clken     (clken),
        .dbus_in   (dbus_in),
        .dbus_out  (dbus_out),
        .io_out_en (io_out_en),
        .ramadr    (ramadr),
        .ramre     (ramre),
        .ramwe     (ramwe),
        .dm_sel    (dm_sel)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp_v);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        dm_sel = 1'b1; ramadr = a; dbus_in = d; ramwe = 1'b1;
        @(posedge clk);
        #1;
        dm_sel = 1'b0; ramwe = 1'b0; dbus_in = 8'h00;
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp_v, input string tag);
        @(negedge clk);
        dm_sel = 1'b1; ramadr = a; ramre = 1'b1;
        #1;
        chk(tag, dbus_out, exp_v);
        chk({tag, "_oe"}, {7'd0, io_out_en}, (a == A_DATA) ? 8'h00 : 8'h01);
        @(posedge clk);
        #1;
        dm_sel = 1'b0; ramre = 1'b0;
    endtask

    task automatic lock_seq();
        wr(A_DATA, 8'h01);
        wr(A_DATA, 8'h02);
        wr(A_DATA, 8'h04);
        wr(A_DATA, 8'h08);
    endtask

    task automatic force_err(input logic [15:0] v);
        @(negedge clk);
        force dut.errcnt = v;
        #1;
        release dut.errcnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clken = 1'b1; dbus_in = 8'h00; ramadr = 8'h00;
        ramre = 1'b0; ramwe = 1'b0; dm_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        rd_chk(A_CTRL, 8'h00, "rst_ctrl");
        rd_chk(A_STAT, 8'h00, "rst_stat");
        rd_chk(A_ERRL, 8'h00, "rst_errl");
        rd_chk(A_ERRH, 8'h00, "rst_errh");
        @(negedge clk);
        ramre = 1'b1; ramadr = A_STAT; dm_sel = 1'b0;
        #1;
        chk("idle_dbus", dbus_out, 8'h00);
        chk("idle_oe", {7'd0, io_out_en}, 8'h00);
        ramre = 1'b0;

        // Write with clken low is ignored
        clken = 1'b0;
        wr(A_CTRL, 8'h01);
        clken = 1'b1;
        rd_chk(A_CTRL, 8'h00, "clken_gate");

        // Lock acquisition
        wr(A_CTRL, 8'h01);
        rd_chk(A_STAT, 8'h01, "start_hunt");
        rd_chk(A_CTRL, 8'h01, "ctrl_en");
        wr(A_DATA, 8'h01);
        rd_chk(A_STAT, 8'h02, "verify");
        rd_chk(A_DATA, 8'h00, "data_rd");
        wr(A_DATA, 8'h02);
        wr(A_DATA, 8'h04);
        rd_chk(A_STAT, 8'h02, "verify2");
        wr(A_DATA, 8'h08);
        rd_chk(A_STAT, 8'h03, "locked");
        rd_chk(A_ERRL, 8'h00, "lock_errl");

        // Error counting while locked
        wr(A_DATA, 8'h11);
        wr(A_DATA, 8'h20);
        rd_chk(A_STAT, 8'h07, "last_err_set");
        wr(A_DATA, 8'h47);
        rd_chk(A_STAT, 8'h03, "last_err_clr");
        wr(A_DATA, 8'h8E);
        rd_chk(A_ERRL, EXP_ERR1, "err_cnt");
        wr(A_STAT, 8'hFF);
        rd_chk(A_STAT, 8'h03, "stat_ro");

        // Loss of lock
        wr(A_CTRL, 8'h03);
        rd_chk(A_ERRL, 8'h00, "clr_errl");
        lock_seq();
        rd_chk(A_STAT, 8'h03, "relock");
        wr(A_DATA, 8'h55);
        wr(A_DATA, 8'h55);
        wr(A_DATA, 8'h55);
        rd_chk(A_STAT, 8'h07, "loss_3");
        wr(A_DATA, 8'h55);
        rd_chk(A_STAT, 8'h05, "loss_hunt");
        rd_chk(A_ERRL, EXP_LOSS, "loss_errl");
        wr(A_DATA, 8'h00);
        rd_chk(A_STAT, 8'h05, "hunt_zero");
        wr(A_DATA, 8'h01);
        rd_chk(A_STAT, 8'h06, "hunt_verify");

        // Saturation
        wr(A_DATA, 8'h02);
        wr(A_DATA, 8'h04);
        wr(A_DATA, 8'h08);
        rd_chk(A_STAT, 8'h07, "sat_locked");
        force_err(16'hFFFE);
        wr(A_DATA, 8'h10);
        wr(A_DATA, 8'h22);
        wr(A_DATA, 8'h46);
        rd_chk(A_ERRL, 8'hFF, "sat_errl");
        rd_chk(A_ERRH, 8'hFF, "sat_errh");
        rd_chk(A_STAT, 8'h0F, "sat_stat");
        wr(A_CTRL, 8'h03);
        rd_chk(A_STAT, 8'h01, "clr_stat");
        rd_chk(A_CTRL, 8'h01, "clr_reads0");
        rd_chk(A_ERRL, 8'h00, "clr_errl2");

        // Atomic 16-bit read across a carry
        lock_seq();
        force_err(16'h00FF);
        rd_chk(A_ERRL, 8'hFF, "atom_errl");
        wr(A_DATA, 8'h10);
        rd_chk(A_ERRH, 8'h00, "atom_shadow");
        rd_chk(A_ERRL, 8'h00, "atom_errl2");
        rd_chk(A_ERRH, 8'h01, "atom_errh2");

        // Mid-stream reset during a DATA write
        @(negedge clk);
        dm_sel = 1'b1; ramadr = A_DATA; dbus_in = 8'h23; ramwe = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; dm_sel = 1'b0; ramwe = 1'b0; dbus_in = 8'h00;
        rd_chk(A_STAT, 8'h00, "mrst_stat");
        rd_chk(A_CTRL, 8'h00, "mrst_ctrl");
        rd_chk(A_ERRL, 8'h00, "mrst_errl");
        rd_chk(A_ERRH, 8'h00, "mrst_errh");
        wr(A_CTRL, 8'h01);
        rd_chk(A_STAT, 8'h01, "mrst_rehunt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
